// File: rtl/mesh_arb_pkg.sv
// Shared types and the round-robin search helper for the mesh terminal injection arbiter.
package mesh_arb_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam int MAX_REQ       = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_PAKG_SIZE = 32;
  localparam int DEF_BURST     = 4;
  localparam int IDX_W         = $clog2(DEF_NUM_REQ);
  // Wide enough for any BURST up to 15.
  localparam int BURST_W       = 4;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0] ptr,
                                    input int n);
    pick_t p;
    int    idx;
    p = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !p.found && req[idx]) begin
        p.found = 1'b1;
        p.idx   = 3'(idx);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mesh_term_inject_arb_if.sv
// Bundle between the local packet sources, the injection arbiter and one mesh terminal.
interface mesh_term_inject_arb_if
  import mesh_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int PAKG_SIZE = DEF_PAKG_SIZE
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Both sides are valid/consume pairs: a transfer happens at an edge where
  // the pending bit (valid) and the matching pop (consume) are both high.
  // req_pndng/req_pop face the sources, pndng_i_in/popin face the router.
  logic [NUM_REQ-1:0]           req_pndng;
  logic [NUM_REQ*PAKG_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_pop;
  logic                         pndng_i_in;
  logic [PAKG_SIZE-1:0]         data_out_i_in;
  logic                         popin;
  logic [IW-1:0]                grant_id;
  logic                         err_o;
  state_t                       dbg_state;
  logic [IW-1:0]                dbg_rr_ptr;
  logic [BURST_W-1:0]           dbg_burst_cnt;

  modport master (
    input  req_pndng, req_data, popin,
    output req_pop, pndng_i_in, data_out_i_in, grant_id, err_o,
           dbg_state, dbg_rr_ptr, dbg_burst_cnt
  );

  modport slave (
    output req_pndng, req_data, popin,
    input  req_pop, pndng_i_in, data_out_i_in, grant_id, err_o,
           dbg_state, dbg_rr_ptr, dbg_burst_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  pick_t              pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    ptr_ext        = '0;
    ptr_ext[IW-1:0] = ptr;
    pick           = rr_pick(req_ext, ptr_ext, N);
    any            = pick.found && (int'(pick.idx) < N);
    gnt_idx        = pick.idx[IW-1:0];
    gnt            = '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mesh_term_inject_arb.sv
// Injection scheduler for one mesh terminal: round-robin with bounded bursts
// into a one-entry output register that the router drains with popin.
module mesh_term_inject_arb
  import mesh_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int PAKG_SIZE = DEF_PAKG_SIZE,
  parameter int BURST     = DEF_BURST
) (
  input logic                    clk,
  input logic                    reset,
  mesh_term_inject_arb_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_next;
  logic [IW-1:0]        rr_ptr, ptr_next, win_idx, grant_q;
  logic [BURST_W-1:0]   burst_cnt, cnt_next;
  logic [NUM_REQ-1:0]   win_gnt;
  logic                 win_any, load;
  logic [PAKG_SIZE-1:0] data_q;
  logic                 err_q;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req     (bus.req_pndng),
    .ptr     (rr_ptr),
    .gnt     (win_gnt),
    .gnt_idx (win_idx),
    .any     (win_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Reload is allowed in the same cycle the router consumes, so a steady
  // stream moves one packet per clock without a bubble.
  always_comb begin
    state_next  = state;
    bus.req_pop = '0;
    load        = !reset && win_any && (state == EMPTY || bus.popin);
    if (load) begin
      state_next  = FULL;
      bus.req_pop = win_gnt;
    end else if (state == FULL && bus.popin) begin
      state_next = EMPTY;
    end
  end

  // A burst continues only while the same index keeps winning back-to-back.
  always_comb begin
    if (win_idx == grant_q && burst_cnt != '0 && burst_cnt < BURST_W'(BURST))
      cnt_next = burst_cnt + 1'b1;
    else
      cnt_next = BURST_W'(1);
    if (cnt_next < BURST_W'(BURST))
      ptr_next = win_idx;
    else if (win_idx == IW'(NUM_REQ - 1))
      ptr_next = '0;
    else
      ptr_next = win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      grant_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (bus.popin && state != FULL) err_q <= 1'b1;
      if (load) begin
        data_q    <= bus.req_data[int'(win_idx)*PAKG_SIZE +: PAKG_SIZE];
        grant_q   <= win_idx;
        burst_cnt <= cnt_next;
        rr_ptr    <= ptr_next;
      end
    end
  end

  assign bus.pndng_i_in    = (state == FULL);
  assign bus.data_out_i_in = data_q;
  assign bus.grant_id      = grant_q;
  assign bus.err_o         = err_q;
  assign bus.dbg_state     = state;
  assign bus.dbg_rr_ptr    = rr_ptr;
  assign bus.dbg_burst_cnt = burst_cnt;

endmodule

// File: doc/mesh_term_inject_arb.md
# mesh_term_inject_arb

Injection-side scheduler for one mesh terminal: arbitrates NUM_REQ local packet sources, each presenting a FIFO-style pending/data/pop interface, onto the single `pndng_i_in`/`data_out_i_in`/`popin` input port of one `mesh_gnrtr` terminal. It uses round-robin order with a bounded burst per grant and holds the selected packet in a one-entry output register until the router pops it. It sits between the per-terminal source FIFOs and the mesh.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PAKG_SIZE, 32, packet width in bits, matches mesh `pckg_sz`
- BURST, 4, max consecutive packets granted to one requester before rotating (1..15)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_pndng  in  NUM_REQ  requester i has a packet at its head
- req_data  in  NUM_REQ*PAKG_SIZE  head packet of requester i; slice i = bits [i*PAKG_SIZE +: PAKG_SIZE]
- req_pop  out  NUM_REQ  one-hot pop to requester i; head removed at that edge
- pndng_i_in  out  1  packet valid toward router terminal
- data_out_i_in  out  PAKG_SIZE  packet toward router terminal
- popin  in  1  router consumes the offered packet at this edge
- grant_id  out  $clog2(NUM_REQ)  source index of the packet currently offered
- err_o  out  1  sticky: popin seen while pndng_i_in low

## Operation
- FSM has two states:
  - EMPTY: output register invalid.
  - FULL: packet offered, waiting for popin.
- load condition: state EMPTY, or state FULL with popin=1; and any req_pndng set.
- On load:
  - winner = first pending index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_pop[winner]=1, combinational in the same cycle.
  - req_data[winner] and winner are captured at the edge.
  - state becomes FULL.
- FULL with popin=1 and no requester pending -> EMPTY.
- FULL with popin=0 -> hold: data, grant_id and state are stable, and req_pop is all zero.
- Burst rule:
  - burst_cnt counts consecutive loads from the same winner.
  - rr_ptr stays on the winner while burst_cnt < BURST and the winner is still pending.
  - When burst_cnt reaches BURST or the winner is not pending, rr_ptr becomes winner+1 (wrapping) and burst_cnt resets to 1 on the next load from a different index.
- req_pop is never asserted for a requester whose req_pndng is low. At most one req_pop bit is set per cycle.
- err_o sets on any edge with popin=1 and pndng_i_in=0. It clears only on reset.

## Timing
- Reset values:
  - state=EMPTY, pndng_i_in=0, data_out_i_in=0, grant_id=0, req_pop=0, err_o=0.
  - rr_ptr=0, burst_cnt=0.
- Reset mid-operation: the offered packet is dropped, not popped back. Requesters keep their heads because req_pop=0 during reset.
- Latency: req_pndng high in cycle t with state EMPTY -> req_pop high in t -> pndng_i_in high from t+1.
- Throughput: with popin=1 every cycle and requesters pending, one packet is transferred per cycle with no bubble (simultaneous consume and reload).
- popin and reload at the same edge: the old packet is consumed and the new one appears in the next cycle. There is no duplication and no loss.
- req_pndng dropping while FULL has no effect on the offered packet.
- NUM_REQ=1: no rotation; burst counting still runs.

## Structure
- Shared package mesh_arb_pkg:
  - state enum {EMPTY, FULL}.
  - localparam IDX_W = $clog2(NUM_REQ).
  - function rr_pick(req, ptr) returning index and found bit.
- Sub-module rr_arbiter, parameterised by N: inputs req and ptr, outputs one-hot gnt, gnt_idx and any. Purely combinational. The parent holds rr_ptr and burst_cnt.
- Top level holds the FSM, output register, burst counter and err_o.

## Test plan
- Reset then idle:
  - stimulus: all req_pndng=0 for 10 cycles.
  - required: pndng_i_in=0, req_pop=0, err_o=0 throughout.
- Single source, popin tied high:
  - stimulus: requester 2 holds 6 packets 0xA0..0xA5.
  - required: data_out_i_in shows 0xA0..0xA5 on consecutive cycles starting one cycle after the first req_pop[2]; grant_id=2.
- Fairness with BURST=4:
  - stimulus: all 4 requesters always pending, popin=1.
  - required: grant_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0.
- Back-pressure:
  - stimulus: popin=0 for 5 cycles while FULL with 0x55.
  - required: data_out_i_in stays 0x55, req_pop=0; after popin=1 the next packet appears the following cycle.
- Error flag:
  - stimulus: popin=1 while EMPTY.
  - required: err_o=1 from the next cycle and stays set until reset.
- Reset mid-burst:
  - stimulus: assert reset while FULL with requester 1.
  - required: pndng_i_in=0 next cycle, rr_ptr=0, and requester 1 head is not popped.
